// File: rtl/param_counter.sv
// Parameterised up/down modulo counter with load, wrap pulse and sticky overflow.
// Define PARAM_COUNTER_SAT_EN to honour the sat input; otherwise the counter always wraps.
module param_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             ovf,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic             sat_on;
    logic             load_ok;
    logic [WIDTH-1:0] load_clamped;

`ifdef PARAM_COUNTER_SAT_EN
    assign sat_on = sat;
`else
    logic unused_sat;
    assign unused_sat = sat;
    assign sat_on     = 1'b0;
`endif

    // Compare in 32 bits so MODULUS == 2**WIDTH never overflows the test.
    assign load_ok      = (32'(load_val) < 32'(MODULUS));
    assign load_clamped = load_ok ? load_val : MAX_VAL;

    assign at_max  = (count == MAX_VAL);
    assign at_zero = (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RST_VAL;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else if (en) begin
            if (up) begin
                if (!at_max) begin
                    count <= count + ONE;
                    wrap  <= 1'b0;
                end else if (sat_on) begin
                    wrap  <= 1'b0;
                    ovf   <= 1'b1;
                end else begin
                    count <= '0;
                    wrap  <= 1'b1;
                    ovf   <= 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count <= count - ONE;
                    wrap  <= 1'b0;
                end else if (sat_on) begin
                    wrap  <= 1'b0;
                    ovf   <= 1'b1;
                end else begin
                    count <= MAX_VAL;
                    wrap  <= 1'b1;
                    ovf   <= 1'b1;
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_counter.sv
// Scoreboard bench for param_counter: a MODULUS=10 instance and a MODULUS=2 instance.
// Saturation expectations follow PARAM_COUNTER_SAT_EN.
module tb_param_counter;

    typedef struct {
        string    name;
        bit       sel;
        bit [3:0] cnt;
        bit       wr;
        bit       ov;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset = 1'b0, a_en = 1'b0, a_up = 1'b0, a_load = 1'b0, a_sat = 1'b0;
    logic [3:0] a_load_val = '0;
    logic [3:0] a_count;
    logic       a_wrap, a_ovf, a_at_max, a_at_zero;

    logic       b_reset = 1'b0, b_en = 1'b0, b_up = 1'b0, b_load = 1'b0, b_sat = 1'b0;
    logic [1:0] b_load_val = '0;
    logic [1:0] b_count;
    logic       b_wrap, b_ovf, b_at_max, b_at_zero;

    param_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_a (
        .clk(clk), .reset(a_reset), .en(a_en), .up(a_up), .load(a_load),
        .load_val(a_load_val), .sat(a_sat), .count(a_count), .wrap(a_wrap),
        .ovf(a_ovf), .at_max(a_at_max), .at_zero(a_at_zero)
    );

    param_counter #(.WIDTH(2), .MODULUS(2), .RESET_VAL(0)) dut_b (
        .clk(clk), .reset(b_reset), .en(b_en), .up(b_up), .load(b_load),
        .load_val(b_load_val), .sat(b_sat), .count(b_count), .wrap(b_wrap),
        .ovf(b_ovf), .at_max(b_at_max), .at_zero(b_at_zero)
    );

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string nm, input string field, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s.%s: got %0d expected %0d", nm, field, act, req);
    endtask

    // Monitor: one expected entry per edge, sampled just after the edge.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            int   c, w, o, mx, z;
            e = q.pop_front();
            if (e.sel) begin
                c = int'(b_count); w = int'(b_wrap); o = int'(b_ovf);
                mx = int'(b_at_max); z = int'(b_at_zero);
                chk(e.name, "at_max", mx, (e.cnt == 4'd1) ? 1 : 0);
            end else begin
                c = int'(a_count); w = int'(a_wrap); o = int'(a_ovf);
                mx = int'(a_at_max); z = int'(a_at_zero);
                chk(e.name, "at_max", mx, (e.cnt == 4'd9) ? 1 : 0);
            end
            chk(e.name, "count", c, int'(e.cnt));
            chk(e.name, "wrap", w, int'(e.wr));
            chk(e.name, "ovf", o, int'(e.ov));
            chk(e.name, "at_zero", z, (e.cnt == 4'd0) ? 1 : 0);
        end
    end

    // Drive one edge worth of inputs on the selected instance and queue its expectation.
    task automatic step(input bit sel, input bit rst, input bit ld, input bit e,
                        input bit u, input bit s, input bit [3:0] lv,
                        input string nm, input bit [3:0] ec, input bit ew, input bit eo);
        exp_t x;
        @(negedge clk);
        a_reset = 1'b0; a_load = 1'b0; a_en = 1'b0;
        b_reset = 1'b0; b_load = 1'b0; b_en = 1'b0;
        if (sel) begin
            b_reset = rst; b_load = ld; b_en = e; b_up = u; b_sat = s;
            b_load_val = lv[1:0];
        end else begin
            a_reset = rst; a_load = ld; a_en = e; a_up = u; a_sat = s;
            a_load_val = lv;
        end
        x.name = nm; x.sel = sel; x.cnt = ec; x.wr = ew; x.ov = eo;
        q.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit [3:0] v;
        // Reset state
        step(0, 1, 0, 0, 0, 0, 0, "rst0", 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, "rst1", 0, 0, 0);
        // Up count through the wrap 9 -> 0
        for (int i = 1; i <= 12; i++) begin
            v = 4'(i % 10);
            step(0, 0, 0, 1, 1, 0, 0, "up", v, i == 10, i >= 10);
        end
        // Out-of-range load clamps and clears ovf
        step(0, 0, 1, 0, 0, 0, 13, "load13", 9, 0, 0);
        // Down count through the wrap 0 -> 9
        for (int i = 1; i <= 10; i++) begin
            v = (i == 10) ? 4'd9 : 4'(9 - i);
            step(0, 0, 0, 1, 0, 0, 0, "down", v, i == 10, i == 10);
        end
        // Top end with sat=1
        step(0, 0, 1, 0, 0, 0, 9, "load9", 9, 0, 0);
`ifdef PARAM_COUNTER_SAT_EN
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 1, 0, "sat_up", 9, 0, 1);
`else
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 1, 0, "sat_up", 4'(i), i == 0, 1);
`endif
        // Bottom end with sat=1
        step(0, 0, 1, 0, 0, 0, 0, "load0", 0, 0, 0);
`ifdef PARAM_COUNTER_SAT_EN
        step(0, 0, 0, 1, 0, 1, 0, "sat_dn", 0, 0, 1);
`else
        step(0, 0, 0, 1, 0, 1, 0, "sat_dn", 9, 1, 1);
`endif
        // Priorities
        step(0, 0, 1, 1, 1, 0, 5, "load_en", 5, 0, 0);
        step(0, 1, 1, 1, 1, 0, 7, "rst_load", 0, 0, 0);
        // Reset on the wrap edge, then resume
        step(0, 0, 1, 0, 0, 0, 9, "load9b", 9, 0, 0);
        step(0, 1, 0, 1, 1, 0, 0, "rst_wrap", 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0, "resume", 1, 0, 0);
        // Direction toggles and hold
        step(0, 0, 1, 0, 0, 0, 3, "load3", 3, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0, "tog_up", 4, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, "tog_dn", 3, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0, "tog_up2", 4, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, "hold", 4, 0, 0);
        // MODULUS=2: consecutive wraps
        step(1, 1, 0, 0, 0, 0, 0, "m2_rst", 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0, "m2_e1", 1, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0, "m2_e2", 0, 1, 1);
        step(1, 0, 0, 1, 1, 0, 0, "m2_e3", 1, 0, 1);
        step(1, 0, 0, 1, 1, 0, 0, "m2_e4", 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, "m2_idle", 0, 0, 1);
        step(1, 0, 1, 0, 0, 0, 3, "m2_load3", 1, 0, 0);
        @(negedge clk);
        a_en = 1'b0; a_load = 1'b0; a_reset = 1'b0;
        b_en = 1'b0; b_load = 1'b0; b_reset = 1'b0;
        @(posedge clk);
        #3;
        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expected 0", q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits (legal 2..16).
REQ-002 The block SHALL have parameter MODULUS, default 16, giving the count range 0..MODULUS-1 (legal 2..2^WIDTH).
REQ-003 The block SHALL have parameter RESET_VAL, default 0, giving the count value after reset (legal 0..MODULUS-1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: count enable.
REQ-007 The block SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-008 The block SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-009 The block SHALL have port load_val, input, WIDTH bits: the value loaded when load=1.
REQ-010 The block SHALL have port sat, input, 1 bit: 1 = saturate at the range ends, 0 = wrap.
REQ-011 The block SHALL have port count, output, WIDTH bits: the registered count value.
REQ-012 The block SHALL have port wrap, output, 1 bit: registered one-cycle pulse marking a wrap event.
REQ-013 The block SHALL have port ovf, output, 1 bit: sticky flag, set on any wrap or saturation hit.
REQ-014 The block SHALL have ports at_max and at_zero, outputs, 1 bit each: combinational flags, count==MODULUS-1 and count==0.

Function
REQ-015 Priority per rising edge SHALL be: reset > load > en; with none of these asserted, count, wrap=0 and ovf SHALL hold.
REQ-016 Load SHALL set count=load_val when load_val<MODULUS, otherwise MODULUS-1; load SHALL clear ovf and wrap in the same edge.
REQ-017 With en=1 and up=1 and count<MODULUS-1, count SHALL increment by 1 with latency one clock.
REQ-018 With en=1 and up=0 and count>0, count SHALL decrement by 1 with latency one clock.
REQ-019 Up wrap case: en=1, up=1, count==MODULUS-1, sat=0 -> count SHALL become 0 and wrap=1 for exactly one cycle.
REQ-020 Down wrap case: en=1, up=0, count==0, sat=0 -> count SHALL become MODULUS-1 and wrap=1 for exactly one cycle.
REQ-021 In the same cases with saturation active, count SHALL hold, wrap SHALL stay 0 and ovf SHALL set.
REQ-022 ovf SHALL set on every wrap and remain 1 until reset or load.
REQ-023 wrap SHALL be 0 in every cycle not directly following a wrap edge; consecutive wraps (MODULUS=2, en held) SHALL give wrap=1 on consecutive cycles.
REQ-024 Toggling up at any cycle SHALL take effect on the next edge with no lost or extra step.
REQ-025 count SHALL never leave 0..MODULUS-1 for any input sequence, including non-power-of-two MODULUS.

Reset
REQ-026 On a rising edge with reset=1, the block SHALL set count=RESET_VAL, wrap=0 and ovf=0, regardless of load and en.
REQ-027 Reset asserted mid-count SHALL abort the operation with no residual wrap pulse; counting SHALL resume on the first edge after reset=0.

Configuration
REQ-028 With macro PARAM_COUNTER_SAT_EN defined, the sat input SHALL be honoured as in REQ-021.
REQ-029 With PARAM_COUNTER_SAT_EN undefined, sat SHALL be ignored and the block SHALL always wrap (REQ-019/020); ports SHALL be unchanged.

Verification
REQ-030 The bench SHALL check: WIDTH=4, MODULUS=10, reset 2 cycles then en=1, up=1 for 12 edges -> count 1..9,0,1,2, with wrap=1 only on the edge count 9->0 and ovf=1 afterwards.
REQ-031 The bench SHALL check: MODULUS=10, load=1, load_val=13 -> count=9, ovf=0; then up=0 for 10 edges -> 8..0,9 with wrap on 0->9.
REQ-032 The bench SHALL check: with PARAM_COUNTER_SAT_EN defined and sat=1, up=1 from count=9 for 3 edges -> count stays 9, wrap=0, ovf=1; without the macro -> 0,1,2 with wrap pulse.
REQ-033 The bench SHALL check: load=1 and en=1 on the same edge with load_val=5 -> count=5 (load wins); reset=1 with load=1 -> count=RESET_VAL.
REQ-034 The bench SHALL check: reset asserted on the wrap edge (count=9, up=1) -> count=0, wrap=0, ovf=0 on the following cycle.
REQ-035 The bench SHALL check: MODULUS=2, en=1 held for 4 edges -> count 1,0,1,0 with wrap pulses on the second and fourth edges.
